// File: rtl/dbuffer_access_ctrl.sv
// Data-buffer access sequencer: alignment/range check, RMW for sub-word stores, load extension.
// Optional macro DBUF_PERF_EN adds saturating access/exception counters.
module dbuffer_access_ctrl #(
    parameter logic [21:0] BASE_ADDR = 22'h000000,
    parameter int          RAM_AW    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    output logic              req_ready,
    input  logic              load,
    input  logic              store,
    input  logic [1:0]        func2,
    input  logic              ld_unsigned,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              resp_valid,
    output logic [31:0]       rdata,
    output logic              er_load_n,
    output logic              er_load_c,
    output logic              er_store_n,
    output logic              er_store_c,
    output logic [31:0]       bad_addr,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
`ifdef DBUF_PERF_EN
    output logic [15:0]       perf_acc_cnt,
    output logic [15:0]       perf_exc_cnt,
`endif
    input  logic [31:0]       ram_rdata
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] LD_RD   = 3'd1;
    localparam logic [2:0] LD_DATA = 3'd2;
    localparam logic [2:0] ST_RD   = 3'd3;
    localparam logic [2:0] ST_WR   = 3'd4;
    localparam logic [2:0] EXC     = 3'd5;

    logic [2:0]  state_r, state_nxt_s;
    logic [31:0] addr_r, wdata_r;
    logic [1:0]  func2_r;
    logic        uns_r, is_store_r, nonalign_r, cross_r;
    logic        accept_s, nonalign_s, cross_s;

    function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                                 input logic [1:0] lane, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            2'b00:   r = uns ? {24'h000000, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'h0000, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wd,
                                                input logic [1:0] size, input logic [1:0] lane);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00: r[{lane, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (lane[1]) r[31:16] = wd[15:0];
                else         r[15:0]  = wd[15:0];
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Accept qualification and access checks on the live request
    always_comb begin
        accept_s   = req && (load || store) && (state_r == IDLE);
        nonalign_s = ((func2 == 2'b01) && addr[0]) ||
                     ((func2 == 2'b10) && (addr[1:0] != 2'b00)) ||
                     (func2 == 2'b11);
        cross_s    = (addr[31:10] != BASE_ADDR);
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (nonalign_s || cross_s)  state_nxt_s = EXC;
                    else if (!store)            state_nxt_s = LD_RD;
                    else if (func2 == 2'b10)    state_nxt_s = ST_WR;
                    else                        state_nxt_s = ST_RD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LD_RD:   state_nxt_s = LD_DATA;
            ST_RD:   state_nxt_s = ST_WR;
            LD_DATA, ST_WR, EXC: state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State, latched request fields and check results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            addr_r     <= 32'h00000000;
            wdata_r    <= 32'h00000000;
            func2_r    <= 2'b00;
            uns_r      <= 1'b0;
            is_store_r <= 1'b0;
            nonalign_r <= 1'b0;
            cross_r    <= 1'b0;
            bad_addr   <= 32'h00000000;
        end else begin
            state_r <= state_nxt_s;
            if (accept_s) begin
                addr_r     <= addr;
                wdata_r    <= wdata;
                func2_r    <= func2;
                uns_r      <= ld_unsigned;
                is_store_r <= store;
                nonalign_r <= nonalign_s;
                cross_r    <= cross_s;
            end
            if (state_r == EXC) bad_addr <= addr_r;
        end
    end

    // RAM and response outputs; read data is only meaningful the cycle after a strobe
    always_comb begin
        req_ready  = (state_r == IDLE);
        resp_valid = 1'b0;
        rdata      = 32'h00000000;
        er_load_n  = 1'b0;
        er_load_c  = 1'b0;
        er_store_n = 1'b0;
        er_store_c = 1'b0;
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_wdata  = 32'h00000000;
        ram_addr   = (state_r != IDLE) ? addr_r[RAM_AW+1:2] : {RAM_AW{1'b0}};
        case (state_r)
            LD_RD, ST_RD: ram_en = 1'b1;
            LD_DATA: begin
                resp_valid = 1'b1;
                rdata      = load_extract(ram_rdata, func2_r, addr_r[1:0], uns_r);
            end
            ST_WR: begin
                ram_en     = 1'b1;
                ram_we     = 1'b1;
                resp_valid = 1'b1;
                ram_wdata  = store_merge(ram_rdata, wdata_r, func2_r, addr_r[1:0]);
            end
            EXC: begin
                resp_valid = 1'b1;
                er_load_n  = !is_store_r && nonalign_r;
                er_load_c  = !is_store_r && cross_r;
                er_store_n = is_store_r && nonalign_r;
                er_store_c = is_store_r && cross_r;
            end
            default: resp_valid = 1'b0;
        endcase
    end

`ifdef DBUF_PERF_EN
    // Saturating response counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_acc_cnt <= 16'h0000;
            perf_exc_cnt <= 16'h0000;
        end else begin
            if (((state_r == LD_DATA) || (state_r == ST_WR)) && (perf_acc_cnt != 16'hFFFF))
                perf_acc_cnt <= perf_acc_cnt + 16'h0001;
            if ((state_r == EXC) && (perf_exc_cnt != 16'hFFFF))
                perf_exc_cnt <= perf_exc_cnt + 16'h0001;
        end
    end
`endif

endmodule

// File: tb/tb_dbuffer_access_ctrl.sv
// Directed bench for dbuffer_access_ctrl with a behavioural 1-cycle-latency RAM.
module tb_dbuffer_access_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, load, store, ld_unsigned;
    logic [1:0]  func2;
    logic [31:0] addr, wdata;
    logic        req_ready, resp_valid;
    logic [31:0] rdata, bad_addr, ram_wdata;
    logic        er_load_n, er_load_c, er_store_n, er_store_c;
    logic        ram_en, ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_rdata;
`ifdef DBUF_PERF_EN
    logic [15:0] perf_acc_cnt, perf_exc_cnt;
`endif

    logic [31:0] mem [0:255];
    logic        pl_en;
    logic [7:0]  pl_addr;
    logic [31:0] pl_data;
    int          n_checks = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    dbuffer_access_ctrl dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_ready(req_ready),
        .load(load), .store(store), .func2(func2), .ld_unsigned(ld_unsigned),
        .addr(addr), .wdata(wdata), .resp_valid(resp_valid), .rdata(rdata),
        .er_load_n(er_load_n), .er_load_c(er_load_c),
        .er_store_n(er_store_n), .er_store_c(er_store_c),
        .bad_addr(bad_addr), .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata),
`ifdef DBUF_PERF_EN
        .perf_acc_cnt(perf_acc_cnt), .perf_exc_cnt(perf_exc_cnt),
`endif
        .ram_rdata(ram_rdata)
    );

    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; presents a request for one edge, returns at the next negedge (cycle +1)
    task automatic issue(input logic l, input logic s, input logic [1:0] f2, input logic u,
                         input logic [31:0] a, input logic [31:0] wd);
        req = 1'b1; load = l; store = s; func2 = f2; ld_unsigned = u; addr = a; wdata = wd;
        @(posedge clk);
        #1;
        req = 1'b0; load = 1'b0; store = 1'b0;
        addr = 32'hFFFFFFFF; wdata = 32'h0; func2 = 2'b11;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req = 1'b0; load = 1'b0; store = 1'b0; func2 = 2'b00;
        ld_unsigned = 1'b0; addr = 32'h0; wdata = 32'h0;
        pl_en = 1'b1; pl_addr = 8'h10; pl_data = 32'h8899AABB;
        @(posedge clk);
        #1 pl_en = 1'b0;
        @(negedge clk);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_ram", {29'h0, resp_valid, ram_en, ram_we}, 32'h0);
        check("rst_bad_addr", bad_addr, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // lb 0x42 signed
        issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h00000042, 32'h0);
        check("lb_c1_strobe", {29'h0, resp_valid, ram_en, ram_we}, 32'h2);
        check("lb_c1_addr", {24'h0, ram_addr}, 32'h10);
        check("lb_c1_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("lb_c2_resp", {31'h0, resp_valid}, 32'h1);
        check("lb_rdata", rdata, 32'hFFFFFF99);
        check("lb_flags", {28'h0, er_load_n, er_load_c, er_store_n, er_store_c}, 32'h0);
        @(negedge clk);
        check("lb_idle", {30'h0, req_ready, resp_valid}, 32'h2);

        // lhu 0x42
        issue(1'b1, 1'b0, 2'b01, 1'b1, 32'h00000042, 32'h0);
        @(negedge clk);
        check("lhu_rdata", rdata, 32'h00008899);
        @(negedge clk);

        // lh 0x40 signed
        issue(1'b1, 1'b0, 2'b01, 1'b0, 32'h00000040, 32'h0);
        @(negedge clk);
        check("lh_rdata", rdata, 32'hFFFFAABB);
        @(negedge clk);

        // sb 0x41: read then merged write
        issue(1'b0, 1'b1, 2'b00, 1'b0, 32'h00000041, 32'h00000055);
        check("sb_c1_rd", {29'h0, resp_valid, ram_en, ram_we}, 32'h2);
        check("sb_c1_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("sb_c2_wr", {29'h0, resp_valid, ram_en, ram_we}, 32'h7);
        check("sb_wdata", ram_wdata, 32'h889955BB);
        check("sb_c2_ready", {31'h0, req_ready}, 32'h0);
        @(negedge clk);
        check("sb_mem", mem[16], 32'h889955BB);
        check("sb_idle", {31'h0, req_ready}, 32'h1);

        // sw 0x44: single write cycle
        issue(1'b0, 1'b1, 2'b10, 1'b0, 32'h00000044, 32'hDEADBEEF);
        check("sw_c1_wr", {29'h0, resp_valid, ram_en, ram_we}, 32'h7);
        check("sw_addr", {24'h0, ram_addr}, 32'h11);
        check("sw_wdata", ram_wdata, 32'hDEADBEEF);
        @(negedge clk);
        check("sw_mem", mem[17], 32'hDEADBEEF);

        // lw 0x402: misaligned and out of range
        issue(1'b1, 1'b0, 2'b10, 1'b0, 32'h00000402, 32'h0);
        check("lw_exc_strobe", {29'h0, resp_valid, ram_en, ram_we}, 32'h4);
        check("lw_exc_flags", {28'h0, er_load_n, er_load_c, er_store_n, er_store_c}, 32'hC);
        check("lw_exc_rdata", rdata, 32'h0);
        @(negedge clk);
        check("lw_bad_addr", bad_addr, 32'h00000402);
        check("lw_idle", {30'h0, req_ready, resp_valid}, 32'h2);

        // sh 0x43: misaligned store only
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h00000043, 32'h0000CAFE);
        check("sh_exc_flags", {28'h0, er_load_n, er_load_c, er_store_n, er_store_c}, 32'h2);
        check("sh_exc_strobe", {29'h0, resp_valid, ram_en, ram_we}, 32'h4);
        @(negedge clk);
        check("sh_bad_addr", bad_addr, 32'h00000043);

        // request with neither load nor store is ignored
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        check("nop_ignored", {29'h0, req_ready, resp_valid, ram_en}, 32'h4);
        @(negedge clk);
        check("nop_still_idle", {29'h0, req_ready, resp_valid, ram_en}, 32'h4);

`ifdef DBUF_PERF_EN
        check("perf_acc", {16'h0, perf_acc_cnt}, 32'h5);
        check("perf_exc", {16'h0, perf_exc_cnt}, 32'h2);
`endif

        // sh 0x40 aborted by reset during the read phase
        issue(1'b0, 1'b1, 2'b01, 1'b0, 32'h00000040, 32'h00001234);
        check("rmw_st_rd", {29'h0, resp_valid, ram_en, ram_we}, 32'h2);
        rst_n = 1'b0;
        #1;
        check("rmw_rst_ram_en", {31'h0, ram_en}, 32'h0);
        check("rmw_rst_ready", {31'h0, req_ready}, 32'h1);
        @(negedge clk);
        check("rmw_mem_kept", mem[16], 32'h889955BB);
`ifdef DBUF_PERF_EN
        check("perf_rst", {perf_acc_cnt, perf_exc_cnt}, 32'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", {29'h0, req_ready, resp_valid, ram_en}, 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/dbuffer_access_ctrl.md
Name: dbuffer_access_ctrl

Overview:
- Sequences every MEM-stage load/store into the single-port, word-wide data buffer RAM (1-cycle read latency, no byte enables).
- Checks alignment and address range at accept. Performs read-modify-write for byte/half stores. Extracts and extends load data.
- Returns one response per request, with exception flags for the trap logic.
- Sits between the MEM-stage pipeline register and the data RAM, and stalls the pipeline while busy.

Parameters:
- BASE_ADDR, 22'h000000, value that addr[31:10] must equal for an in-range access (1 KB window).
- RAM_AW, 8, RAM word-address width; RAM address = addr[RAM_AW+1:2].

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- req  in  1  access request; held by requester until accepted
- req_ready  out  1  high only in IDLE; accept = req & req_ready
- load  in  1  request is a load
- store  in  1  request is a store; takes priority if load also high
- func2  in  2  size: 00 byte, 01 half, 10 word, 11 illegal
- ld_unsigned  in  1  zero-extend (lbu/lhu) when 1, sign-extend when 0
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse; completion or exception
- rdata  out  32  load result, valid with resp_valid on loads, else 0
- er_load_n / er_load_c / er_store_n / er_store_c  out  1 each  misaligned / out-of-range flags, valid only with resp_valid
- bad_addr  out  32  latched faulting address, updated on exception
- ram_en, ram_we  out  1 each  RAM strobe / write enable
- ram_addr  out  RAM_AW  RAM word address
- ram_wdata  out  32  RAM write word
- ram_rdata  in  32  RAM read word, valid the cycle after a read strobe

Behaviour:
- Reset (async, immediate): state IDLE. All outputs 0 except req_ready=1. Registered request fields cleared. bad_addr=0.
- Misaligned (nonalign) check: func2=01 & addr[0]; func2=10 & addr[1:0]!=0; func2=11 always.
- Out-of-range (crossborder) check: addr[31:10]!=BASE_ADDR.
- Both checks are evaluated at accept. Requests with neither load nor store are ignored.
- Accept: latch addr, func2, ld_unsigned, wdata and the op. Next state:
  - EXC if either check fails.
  - LD_RD for loads.
  - ST_WR for word stores.
  - ST_RD for byte/half stores.
- LD_RD: ram_en=1, ram_we=0 → LD_DATA.
- LD_DATA:
  - Select lane from ram_rdata: byte lane addr[1:0]; half lane addr[1].
  - Extend per ld_unsigned into rdata. resp_valid=1 → IDLE.
  - Load latency: resp 2 cycles after accept.
- ST_RD: ram_en=1, ram_we=0 → ST_WR.
- ST_WR:
  - Word store: ram_wdata = wdata.
  - Sub-word store: ram_wdata = ram_rdata with the addressed byte/half replaced by wdata[7:0]/[15:0].
  - ram_en=1, ram_we=1, resp_valid=1 → IDLE.
  - Store latency: word 1 cycle, sub-word 2 cycles after accept.
- EXC:
  - No RAM strobe.
  - resp_valid=1 with the flags raised. Both _n and _c may be set together.
  - Load flags for loads, store flags for stores. bad_addr <= addr.
  - → IDLE. Exception latency: 1 cycle.
- Throughput: next request is accepted in the IDLE cycle following any resp_valid. No overlap between requests.
- ram_addr holds the latched word address in every non-IDLE state. ram_en is never high in IDLE or EXC.
- Reset mid-RMW: abort. RAM is untouched, because a write occurs only in ST_WR.
- Input changes while busy are ignored; only latched values are used.

Optional Feature:
- Macro DBUF_PERF_EN.
- When defined, adds two outputs, perf_acc_cnt[15:0] and perf_exc_cnt[15:0]:
  - perf_acc_cnt increments on each non-exception resp_valid.
  - perf_exc_cnt increments on each EXC response.
  - Both saturate at 16'hFFFF and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- RAM word 0x10 = 32'h8899AABB; lb addr 32'h00000042, ld_unsigned=0 → resp_valid 2 cycles after accept, rdata 32'hFFFFFF99.
- Same word; lhu addr 32'h00000042 → rdata 32'h00008899.
- sb addr 32'h00000041, wdata 32'h00000055 → ST_RD then ST_WR, ram_wdata 32'h8899_55BB, resp at +2, req_ready low for 2 cycles.
- sw addr 32'h00000044, wdata 32'hDEADBEEF → single write cycle at +1, ram_addr 8'h11.
- lw addr 32'h00000402 (BASE 0) → no RAM strobe, resp at +1, er_load_n=1, er_load_c=1, bad_addr 32'h00000402.
- Assert rst_n low in ST_RD of an sh → state IDLE, ram_en=0 immediately, RAM word unchanged. With DBUF_PERF_EN, counters read 0.
